// File: rtl/noc_link_arbiter_if.sv
// Bundle of requester-side and link-side signals shared by noc_link_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requesters and consumes the link (including credit return).
interface noc_link_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int FLIT_WIDTH  = 128,
    parameter int USER_WIDTH  = 32,
    parameter int DEST_WIDTH  = 8,
    parameter int NUM_CREDITS = 8
);
    localparam int CNT_W = $clog2(NUM_CREDITS + 1);

    logic [NUM_REQ*FLIT_WIDTH-1:0] req_data_in;
    logic [NUM_REQ*DEST_WIDTH-1:0] req_dest_in;
    logic [NUM_REQ*USER_WIDTH-1:0] req_user_in;
    logic [NUM_REQ-1:0]            req_is_tail_in;
    logic [NUM_REQ-1:0]            req_valid_in;
    logic [NUM_REQ-1:0]            req_ready_out;

    logic [FLIT_WIDTH-1:0]         data_out;
    logic [DEST_WIDTH-1:0]         dest_out;
    logic [USER_WIDTH-1:0]         user_out;
    logic                          is_tail_out;
    logic                          send_out;

    logic                          credit_in;
    logic [CNT_W-1:0]              credit_count_out;
    logic                          credit_err_out;

    modport master (
        output req_data_in,
        output req_dest_in,
        output req_user_in,
        output req_is_tail_in,
        output req_valid_in,
        input  req_ready_out,
        input  data_out,
        input  dest_out,
        input  user_out,
        input  is_tail_out,
        input  send_out,
        output credit_in,
        input  credit_count_out,
        input  credit_err_out
    );

    modport slave (
        input  req_data_in,
        input  req_dest_in,
        input  req_user_in,
        input  req_is_tail_in,
        input  req_valid_in,
        output req_ready_out,
        output data_out,
        output dest_out,
        output user_out,
        output is_tail_out,
        output send_out,
        input  credit_in,
        output credit_count_out,
        output credit_err_out
    );
endinterface

// File: rtl/noc_link_arbiter.sv
// Wormhole round-robin arbiter sharing one credit-flow-controlled NoC link.
// A head flit locks the link to its requester until that packet's tail flit
// goes out; a flit is only accepted while at least one downstream credit is held.
module noc_link_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FLIT_WIDTH  = 128,
    parameter int USER_WIDTH  = 32,
    parameter int DEST_WIDTH  = 8,
    parameter int NUM_CREDITS = 8
) (
    input logic              clk,
    input logic              rst_n,
    noc_link_arbiter_if.slave link
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(NUM_CREDITS + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [PTR_W-1:0] LAST_REQ    = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] MAX_CREDITS = CNT_W'(NUM_CREDITS);

    logic [0:0]            state_q, state_d;
    logic [PTR_W-1:0]      rrPtr_q, rrPtr_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [CNT_W-1:0]      creditCnt_q, creditCnt_d;
    logic                  creditErr_q, creditErr_d;

    logic                  send_q;
    logic [FLIT_WIDTH-1:0] data_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [USER_WIDTH-1:0] user_q;
    logic                  isTail_q;

    logic                  pickFound;
    logic [PTR_W-1:0]      pickIdx;
    logic [PTR_W-1:0]      cand;
    logic                  fire;
    logic [PTR_W-1:0]      fireIdx;
    logic [NUM_REQ-1:0]    readyVec;

    logic [FLIT_WIDTH-1:0] selData;
    logic [DEST_WIDTH-1:0] selDest;
    logic [USER_WIDTH-1:0] selUser;
    logic                  selTail;

    // Round-robin search: first valid requester strictly after rrPtr_q, wrapping.
    always_comb begin
        pickFound = 1'b0;
        pickIdx   = '0;
        cand      = rrPtr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == LAST_REQ) ? '0 : cand + PTR_W'(1);
            if (!pickFound && link.req_valid_in[cand]) begin
                pickFound = 1'b1;
                pickIdx   = cand;
            end
        end
    end

    // Grant: the round-robin pick when idle, only the owner when locked, nobody without credit.
    always_comb begin
        fire     = 1'b0;
        fireIdx  = owner_q;
        readyVec = '0;
        if (creditCnt_q != '0) begin
            if (state_q == ST_IDLE) begin
                fire    = pickFound;
                fireIdx = pickIdx;
            end else begin
                fire    = link.req_valid_in[owner_q];
                fireIdx = owner_q;
            end
        end
        if (fire) begin
            readyVec[fireIdx] = 1'b1;
        end
    end

    assign link.req_ready_out = readyVec;

    // Select the flit fields of the requester being granted this cycle.
    always_comb begin
        selData = '0;
        selDest = '0;
        selUser = '0;
        selTail = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fireIdx == PTR_W'(i)) begin
                selData = link.req_data_in[i*FLIT_WIDTH +: FLIT_WIDTH];
                selDest = link.req_dest_in[i*DEST_WIDTH +: DEST_WIDTH];
                selUser = link.req_user_in[i*USER_WIDTH +: USER_WIDTH];
                selTail = link.req_is_tail_in[i];
            end
        end
    end

    // Packet lock tracking: a head flit locks the owner, its tail releases and moves the pointer.
    always_comb begin
        state_d = state_q;
        rrPtr_d = rrPtr_q;
        owner_d = owner_q;
        if (fire) begin
            if (state_q == ST_IDLE) begin
                if (selTail) begin
                    rrPtr_d = fireIdx;
                end else begin
                    state_d = ST_LOCKED;
                    owner_d = fireIdx;
                end
            end else if (selTail) begin
                state_d = ST_IDLE;
                rrPtr_d = owner_q;
            end
        end
    end

    // Credit bookkeeping: a send consumes one, a return adds one, a return at full is an error.
    always_comb begin
        creditCnt_d = creditCnt_q;
        creditErr_d = creditErr_q;
        if (fire && !link.credit_in) begin
            creditCnt_d = creditCnt_q - CNT_W'(1);
        end else if (!fire && link.credit_in) begin
            if (creditCnt_q == MAX_CREDITS) begin
                creditErr_d = 1'b1;
            end else begin
                creditCnt_d = creditCnt_q + CNT_W'(1);
            end
        end
    end

    // Arbitration state and credit registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rrPtr_q     <= LAST_REQ;
            owner_q     <= '0;
            creditCnt_q <= MAX_CREDITS;
            creditErr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rrPtr_q     <= rrPtr_d;
            owner_q     <= owner_d;
            creditCnt_q <= creditCnt_d;
            creditErr_q <= creditErr_d;
        end
    end

    // Link output register: one-cycle send pulse per flit, payload holds between flits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_q   <= 1'b0;
            data_q   <= '0;
            dest_q   <= '0;
            user_q   <= '0;
            isTail_q <= 1'b0;
        end else begin
            send_q <= fire;
            if (fire) begin
                data_q   <= selData;
                dest_q   <= selDest;
                user_q   <= selUser;
                isTail_q <= selTail;
            end
        end
    end

    assign link.send_out         = send_q;
    assign link.data_out         = data_q;
    assign link.dest_out         = dest_q;
    assign link.user_out         = user_q;
    assign link.is_tail_out      = isTail_q;
    assign link.credit_count_out = creditCnt_q;
    assign link.credit_err_out   = creditErr_q;
endmodule

// File: tb/tb_noc_link_arbiter.sv
// Testbench for noc_link_arbiter: reset, a vector table for round-robin and
// wormhole locking, credit stall/error sequences, then random traffic against
// a packet-level reference model with per-requester ordering checks.
module tb_noc_link_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int FLIT_WIDTH  = 128;
    localparam int USER_WIDTH  = 32;
    localparam int DEST_WIDTH  = 8;
    localparam int NUM_CREDITS = 8;
    localparam int PTR_W       = $clog2(NUM_REQ);
    localparam int NUM_VECS    = 18;

    logic clk = 1'b0;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    logic [FLIT_WIDTH-1:0] offData [NUM_REQ];
    logic [DEST_WIDTH-1:0] offDest [NUM_REQ];
    logic [USER_WIDTH-1:0] offUser [NUM_REQ];
    logic                  offTail [NUM_REQ];
    logic                  offValid[NUM_REQ];

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        logic [NUM_REQ-1:0] tail;
        logic               cr;
        logic [NUM_REQ-1:0] expReady;
        logic               expSend;
        int                 expCnt;
    } vec_t;

    vec_t vecs[NUM_VECS];

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    noc_link_arbiter_if #(
        .NUM_REQ(NUM_REQ), .FLIT_WIDTH(FLIT_WIDTH), .USER_WIDTH(USER_WIDTH),
        .DEST_WIDTH(DEST_WIDTH), .NUM_CREDITS(NUM_CREDITS)
    ) linkIf ();

    noc_link_arbiter #(
        .NUM_REQ(NUM_REQ), .FLIT_WIDTH(FLIT_WIDTH), .USER_WIDTH(USER_WIDTH),
        .DEST_WIDTH(DEST_WIDTH), .NUM_CREDITS(NUM_CREDITS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .link(linkIf.slave)
    );

    task automatic checkOutput(input string name, input logic [FLIT_WIDTH-1:0] actual,
                               input logic [FLIT_WIDTH-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic cr);
        for (int i = 0; i < NUM_REQ; i++) begin
            linkIf.req_data_in[i*FLIT_WIDTH +: FLIT_WIDTH] = offData[i];
            linkIf.req_dest_in[i*DEST_WIDTH +: DEST_WIDTH] = offDest[i];
            linkIf.req_user_in[i*USER_WIDTH +: USER_WIDTH] = offUser[i];
            linkIf.req_is_tail_in[i]                       = offTail[i];
            linkIf.req_valid_in[i]                         = offValid[i];
        end
        linkIf.credit_in = cr;
        #1;
    endtask

    task automatic clockCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [FLIT_WIDTH-1:0] tableFlit(input int vecIdx, input int req);
        return {64'(vecIdx), 32'(req), 32'hC0DE_0000 + 32'(req)};
    endfunction

    task automatic setOffers(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ-1:0] tail,
                             input int tag);
        for (int i = 0; i < NUM_REQ; i++) begin
            offValid[i] = valid[i];
            offTail[i]  = tail[i];
            offData[i]  = tableFlit(tag, i);
            offDest[i]  = 8'h10 + 8'(i);
            offUser[i]  = 32'hA000_0000 + 32'(i);
        end
    endtask

    // Reference model state: lock owner (-1 when none), last served requester, credits.
    int mOwner, mLast, mCredits;
    bit mErr;

    function automatic int modelGrant();
        if (mCredits == 0) return -1;
        if (mOwner >= 0) return offValid[mOwner] ? mOwner : -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c = (mLast + k) % NUM_REQ;
            if (offValid[c]) return c;
        end
        return -1;
    endfunction

    initial begin
        logic [FLIT_WIDTH-1:0] holdData;
        logic [DEST_WIDTH-1:0] holdDest;
        logic                  holdTail;
        int                    fires;

        //           valid    tail     cr    expReady expSend expCnt
        vecs[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 8};
        vecs[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 8};
        vecs[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 8};
        vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 8};
        vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 8};
        vecs[5]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 8};
        vecs[6]  = '{4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 8};
        vecs[7]  = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b1, 7};
        vecs[8]  = '{4'b0110, 4'b0010, 1'b0, 4'b0010, 1'b1, 6};
        vecs[9]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 6};
        vecs[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 7};
        vecs[11] = '{4'b1011, 4'b1111, 1'b0, 4'b1000, 1'b1, 6};
        vecs[12] = '{4'b1011, 4'b1111, 1'b0, 4'b0001, 1'b1, 5};
        vecs[13] = '{4'b1011, 4'b1111, 1'b0, 4'b0010, 1'b1, 4};
        vecs[14] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 5};
        vecs[15] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 6};
        vecs[16] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 7};
        vecs[17] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8};

        setOffers(4'b0000, 4'b0000, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("reset_send", linkIf.send_out, 0);
        checkOutput("reset_credits", linkIf.credit_count_out, NUM_CREDITS);
        checkOutput("reset_err", linkIf.credit_err_out, 0);
        checkOutput("reset_data", linkIf.data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Requester 3 starts a packet, then reset lands mid-packet.
        setOffers(4'b1000, 4'b0000, 100);
        applyStimulus(1'b0);
        checkOutput("mid_head_ready", linkIf.req_ready_out, 4'b1000);
        clockCycle();
        checkOutput("mid_head_send", linkIf.send_out, 1);
        checkOutput("mid_head_credits", linkIf.credit_count_out, 7);
        setOffers(4'b1001, 4'b0000, 101);
        applyStimulus(1'b0);
        checkOutput("mid_body_ready", linkIf.req_ready_out, 4'b1000);
        clockCycle();
        checkOutput("mid_body_credits", linkIf.credit_count_out, 6);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_send", linkIf.send_out, 0);
        checkOutput("async_reset_credits", linkIf.credit_count_out, NUM_CREDITS);
        checkOutput("async_reset_data", linkIf.data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        holdData = '0;
        holdDest = '0;
        holdTail = 1'b0;
        for (int v = 0; v < NUM_VECS; v++) begin
            setOffers(vecs[v].valid, vecs[v].tail, v);
            applyStimulus(vecs[v].cr);
            checkOutput($sformatf("vec%0d_ready", v), linkIf.req_ready_out, vecs[v].expReady);
            if (vecs[v].expSend) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (vecs[v].expReady[i]) begin
                        holdData = tableFlit(v, i);
                        holdDest = 8'h10 + 8'(i);
                        holdTail = vecs[v].tail[i];
                    end
                end
            end
            clockCycle();
            checkOutput($sformatf("vec%0d_send", v), linkIf.send_out, vecs[v].expSend);
            checkOutput($sformatf("vec%0d_data", v), linkIf.data_out, holdData);
            checkOutput($sformatf("vec%0d_dest", v), linkIf.dest_out, holdDest);
            checkOutput($sformatf("vec%0d_tail", v), linkIf.is_tail_out, holdTail);
            checkOutput($sformatf("vec%0d_credits", v), linkIf.credit_count_out, vecs[v].expCnt);
        end

        // Credit stall: with no returns exactly NUM_CREDITS flits get through.
        fires = 0;
        setOffers(4'b0001, 4'b1111, 200);
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0);
            if (linkIf.req_ready_out[0]) fires++;
            clockCycle();
        end
        checkOutput("stall_fires", fires, NUM_CREDITS);
        checkOutput("stall_credits", linkIf.credit_count_out, 0);
        applyStimulus(1'b1);
        checkOutput("stall_ready_at_zero", linkIf.req_ready_out, 4'b0000);
        clockCycle();
        checkOutput("stall_one_credit", linkIf.credit_count_out, 1);
        fires = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0);
            if (linkIf.req_ready_out[0]) fires++;
            clockCycle();
        end
        checkOutput("stall_extra_fire", fires, 1);

        // Fire plus return at count 3 leaves the count alone; a return at full is an error.
        setOffers(4'b0000, 4'b0000, 300);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1);
            clockCycle();
        end
        checkOutput("cr_count3", linkIf.credit_count_out, 3);
        setOffers(4'b0001, 4'b0001, 301);
        applyStimulus(1'b1);
        checkOutput("cr_fire_ready", linkIf.req_ready_out, 4'b0001);
        clockCycle();
        checkOutput("cr_fire_and_return", linkIf.credit_count_out, 3);
        setOffers(4'b0000, 4'b0000, 302);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1);
            clockCycle();
        end
        checkOutput("cr_full", linkIf.credit_count_out, NUM_CREDITS);
        checkOutput("cr_no_err_yet", linkIf.credit_err_out, 0);
        applyStimulus(1'b1);
        clockCycle();
        checkOutput("cr_overflow_err", linkIf.credit_err_out, 1);
        checkOutput("cr_overflow_count", linkIf.credit_count_out, NUM_CREDITS);
        setOffers(4'b0001, 4'b0001, 303);
        applyStimulus(1'b0);
        clockCycle();
        checkOutput("cr_err_sticky", linkIf.credit_err_out, 1);
        checkOutput("cr_after_err_count", linkIf.credit_count_out, NUM_CREDITS - 1);

        setOffers(4'b0000, 4'b0000, 400);
        applyStimulus(1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_clears_err", linkIf.credit_err_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the packet-level reference model.
        begin
            int  seqOff[NUM_REQ];
            int  lastSeqSent[NUM_REQ];
            int  linkOwner;
            int  g, id, seq;
            logic cr;
            logic expSend;
            logic [NUM_REQ-1:0]    expReadyVec;
            logic [FLIT_WIDTH-1:0] expData;
            logic [DEST_WIDTH-1:0] expDest;
            logic [USER_WIDTH-1:0] expUser;
            logic                  expTail;

            mOwner   = -1;
            mLast    = NUM_REQ - 1;
            mCredits = NUM_CREDITS;
            mErr     = 1'b0;
            linkOwner = -1;
            expData = '0;
            expDest = '0;
            expUser = '0;
            expTail = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                seqOff[i]      = 0;
                lastSeqSent[i] = 0;
                offValid[i]    = 1'b0;
            end

            for (int cyc = 0; cyc < 5000; cyc++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!offValid[i] && $urandom_range(0, 1) == 1) begin
                        seqOff[i]++;
                        offValid[i] = 1'b1;
                        offTail[i]  = ($urandom_range(0, 2) == 0);
                        offData[i]  = {64'(seqOff[i]), 32'(i), 32'($urandom())};
                        offDest[i]  = 8'($urandom());
                        offUser[i]  = 32'($urandom());
                    end
                end
                cr = (mCredits < NUM_CREDITS) && ($urandom_range(0, 9) < 4);
                applyStimulus(cr);

                g = modelGrant();
                expReadyVec = '0;
                expSend = 1'b0;
                if (g >= 0) begin
                    expReadyVec[PTR_W'(g)] = 1'b1;
                    expSend = 1'b1;
                    expData = offData[g];
                    expDest = offDest[g];
                    expUser = offUser[g];
                    expTail = offTail[g];
                end
                checkOutput("rand_ready", linkIf.req_ready_out, expReadyVec);

                if (g >= 0) begin
                    if (mOwner >= 0) begin
                        if (offTail[g]) begin
                            mOwner = -1;
                            mLast  = g;
                        end
                    end else if (offTail[g]) begin
                        mLast = g;
                    end else begin
                        mOwner = g;
                    end
                    offValid[g] = 1'b0;
                end
                if (g >= 0 && !cr) begin
                    mCredits--;
                end else if (g < 0 && cr) begin
                    if (mCredits == NUM_CREDITS) mErr = 1'b1;
                    else mCredits++;
                end

                clockCycle();
                checkOutput("rand_send", linkIf.send_out, expSend);
                if (expSend) begin
                    checkOutput("rand_data", linkIf.data_out, expData);
                    checkOutput("rand_dest", linkIf.dest_out, expDest);
                    checkOutput("rand_user", linkIf.user_out, expUser);
                    checkOutput("rand_tail", linkIf.is_tail_out, expTail);
                    id  = int'(linkIf.data_out[63:32]);
                    seq = int'(linkIf.data_out[127:64]);
                    if (id >= 0 && id < NUM_REQ) begin
                        checkOutput("rand_order", seq, lastSeqSent[id] + 1);
                        lastSeqSent[id] = seq;
                        if (linkOwner >= 0) checkOutput("rand_no_interleave", id, linkOwner);
                        linkOwner = linkIf.is_tail_out ? -1 : id;
                    end else begin
                        checkOutput("rand_id_range", id, 0);
                    end
                end
                checkOutput("rand_credits", linkIf.credit_count_out, mCredits);
                checkOutput("rand_err", linkIf.credit_err_out, mErr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
